// File: rtl/micro_ondas_ctrl_p.sv
// Microwave-oven controller: BCD cooking-time countdown with pause/resume, cancel,
// quarter-second heater power modulation and end-of-cycle buzzer.
module micro_ondas_ctrl_p #(
   parameter int unsigned DIGITOS  = 3,
   parameter int unsigned TICK_DIV = 1000,
   parameter int unsigned BEEP_SEG = 3
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [4*DIGITOS-1:0]   tempo,
   input  logic                   conf,
   input  logic                   cancela,
   input  logic                   porta,
   input  logic [1:0]             potencia,
   output logic [4*DIGITOS-1:0]   leds,
   output logic                   luz,
   output logic                   motor,
   output logic                   aquec,
   output logic                   som,
   output logic [2:0]             est
);

   localparam int unsigned W  = 4 * DIGITOS;
   localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   localparam logic [PW-1:0] PreMax  = PW'(TICK_DIV - 1);
   localparam logic [PW-1:0] Quarter = PW'(TICK_DIV / 4);
   localparam logic [3:0]    BipMax  = 4'(BEEP_SEG - 1);

   typedef enum logic [2:0] {
      StOcioso     = 3'd0,
      StCozinhando = 3'd2,
      StPausado    = 3'd3,
      StFim        = 3'd4
   } state_t;

   state_t         state_q, state_d;
   logic [W-1:0]   cnt_q, cnt_d;
   logic [PW-1:0]  pre_q, pre_d;
   logic [3:0]     bip_q, bip_d;
   logic [1:0]     pot_q, pot_d;

   logic           tick;
   logic [W-1:0]   cnt_dec;
   logic           start_ok;

   function automatic logic tempo_ok(input logic [W-1:0] t);
      logic ok;
      ok = 1'b1;
      for (int i = 0; i < DIGITOS; i++) begin
         if (t[4*i +: 4] > 4'd9) ok = 1'b0;
      end
      return ok;
   endfunction

   // Ripple-borrow BCD decrement: a 0 digit becomes 9 and keeps borrowing.
   function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
      logic [W-1:0] r;
      logic         borrow;
      r      = v;
      borrow = 1'b1;
      for (int i = 0; i < DIGITOS; i++) begin
         if (borrow) begin
            if (v[4*i +: 4] == 4'd0) begin
               r[4*i +: 4] = 4'd9;
            end else begin
               r[4*i +: 4] = v[4*i +: 4] - 4'd1;
               borrow      = 1'b0;
            end
         end
      end
      return r;
   endfunction

   assign tick     = (pre_q == PreMax);
   assign cnt_dec  = bcd_dec(cnt_q);
   assign start_ok = conf && tempo_ok(tempo) && (tempo != '0);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      pre_d   = pre_q;
      bip_d   = bip_q;
      pot_d   = pot_q;
      unique case (state_q)
         StOcioso: begin
            cnt_d = '0;
            if (!cancela && !porta && start_ok) begin
               state_d = StCozinhando;
               cnt_d   = tempo;
               pre_d   = '0;
               pot_d   = potencia;
            end
         end
         StCozinhando: begin
            // Pausing holds cnt/pre so a coincident tick is not lost.
            if (cancela || porta) begin
               state_d = StPausado;
            end else if (tick) begin
               pre_d = '0;
               cnt_d = cnt_dec;
               if (cnt_dec == '0) begin
                  state_d = StFim;
                  bip_d   = '0;
               end
            end else begin
               pre_d = pre_q + PW'(1);
            end
         end
         StPausado: begin
            if (cancela) begin
               state_d = StOcioso;
               cnt_d   = '0;
            end else if (!porta && conf) begin
               state_d = StCozinhando;
               pot_d   = potencia;
            end
         end
         StFim: begin
            cnt_d = '0;
            if (cancela || porta) begin
               state_d = StOcioso;
            end else if (tick) begin
               pre_d = '0;
               if (bip_q == BipMax) state_d = StOcioso;
               else                 bip_d   = bip_q + 4'd1;
            end else begin
               pre_d = pre_q + PW'(1);
            end
         end
         default: begin
            state_d = StOcioso;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StOcioso;
         cnt_q   <= '0;
         pre_q   <= '0;
         bip_q   <= '0;
         pot_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         pre_q   <= pre_d;
         bip_q   <= bip_d;
         pot_q   <= pot_d;
      end
   end

   assign leds  = cnt_q;
   assign motor = (state_q == StCozinhando);
   assign aquec = (state_q == StCozinhando) && ((pre_q / Quarter) <= PW'(pot_q));
   assign som   = (state_q == StFim);
   // Light follows the door combinationally.
   assign luz   = porta || (state_q == StCozinhando);
   assign est   = state_q;

endmodule

// File: tb/tb_micro_ondas_ctrl_p.sv
// Bench for micro_ondas_ctrl_p: directed steps plus random stimulus checked against an
// integer-seconds reference model.
module tb_micro_ondas_ctrl_p;

   localparam int unsigned DIG  = 3;
   localparam int unsigned TDIV = 8;
   localparam int unsigned BEEP = 2;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [4*DIG-1:0]  tempo;
   logic              conf, cancela, porta;
   logic [1:0]        potencia;
   logic [4*DIG-1:0]  leds;
   logic              luz, motor, aquec, som;
   logic [2:0]        est;

   int n_assert = 0;
   int n_fail   = 0;

   // Reference model: state code, seconds remaining as an integer, sub-second phase.
   int m_st, m_secs, m_pre, m_bip, m_pot;

   micro_ondas_ctrl_p #(
      .DIGITOS  (DIG),
      .TICK_DIV (TDIV),
      .BEEP_SEG (BEEP)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .tempo    (tempo),
      .conf     (conf),
      .cancela  (cancela),
      .porta    (porta),
      .potencia (potencia),
      .leds     (leds),
      .luz      (luz),
      .motor    (motor),
      .aquec    (aquec),
      .som      (som),
      .est      (est)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [4*DIG-1:0] to_bcd(input int v);
      logic [4*DIG-1:0] r;
      int               x;
      x = v;
      for (int d = 0; d < DIG; d++) begin
         r[4*d +: 4] = 4'(x % 10);
         x = x / 10;
      end
      return r;
   endfunction

   function automatic int bcd_val(input logic [4*DIG-1:0] t, output bit ok);
      int v, m;
      v  = 0;
      m  = 1;
      ok = 1'b1;
      for (int d = 0; d < DIG; d++) begin
         if (t[4*d +: 4] > 4'd9) ok = 1'b0;
         v = v + int'(t[4*d +: 4]) * m;
         m = m * 10;
      end
      return v;
   endfunction

   task automatic model_reset();
      m_st = 0; m_secs = 0; m_pre = 0; m_bip = 0; m_pot = 0;
   endtask

   task automatic model_step();
      bit ok;
      int val;
      val = bcd_val(tempo, ok);
      case (m_st)
         0: begin
            m_secs = 0;
            if (!cancela && !porta && conf && ok && val != 0) begin
               m_st = 2; m_secs = val; m_pre = 0; m_pot = int'(potencia);
            end
         end
         2: begin
            if (cancela || porta) m_st = 3;
            else begin
               m_pre = (m_pre + 1) % TDIV;
               if (m_pre == 0) begin
                  m_secs--;
                  if (m_secs == 0) begin m_st = 4; m_bip = 0; end
               end
            end
         end
         3: begin
            if (cancela) begin m_st = 0; m_secs = 0; end
            else if (!porta && conf) begin m_st = 2; m_pot = int'(potencia); end
         end
         default: begin
            m_secs = 0;
            if (cancela || porta) m_st = 0;
            else begin
               m_pre = (m_pre + 1) % TDIV;
               if (m_pre == 0) begin
                  if (m_bip == BEEP - 1) m_st = 0;
                  else m_bip++;
               end
            end
         end
      endcase
   endtask

   task automatic check_model();
      chk("leds",  32'(leds),  32'(to_bcd(m_secs)));
      chk("est",   32'(est),   32'(m_st));
      chk("motor", 32'(motor), 32'(m_st == 2));
      chk("aquec", 32'(aquec), 32'(m_st == 2 && (m_pre / (TDIV / 4)) <= m_pot));
      chk("som",   32'(som),   32'(m_st == 4));
      chk("luz",   32'(luz),   32'(porta || m_st == 2));
   endtask

   task automatic cycle();
      @(posedge clk);
      model_step();
      #1;
      check_model();
   endtask

   task automatic idle_inputs();
      conf = 1'b0; cancela = 1'b0; porta = 1'b0;
   endtask

   initial begin
      // Reset with random inputs, door closed
      rst_n    = 1'b0;
      tempo    = 12'($urandom);
      conf     = 1'($urandom);
      cancela  = 1'($urandom);
      potencia = 2'($urandom);
      porta    = 1'b0;
      model_reset();
      #3;
      chk("rst_leds", 32'(leds), 32'h0);
      chk("rst_est", 32'(est), 32'h0);
      chk("rst_outs", 32'({motor, aquec, som, luz}), 32'h0);
      porta = 1'b1;
      #1;
      chk("rst_luz_door", 32'(luz), 32'h1);
      @(negedge clk);
      idle_inputs();
      rst_n = 1'b1;
      cycle();

      // Normal cycle: 3 s at full power
      tempo = 12'h003; potencia = 2'd3; conf = 1'b1;
      cycle();
      chk("start_est", 32'(est), 32'h2);
      chk("start_luz", 32'(luz), 32'h1);
      conf = 1'b0;
      for (int i = 1; i <= 44; i++) begin
         cycle();
         if (i == 8)  chk("norm_leds_k8",  32'(leds), 32'h002);
         if (i == 16) chk("norm_leds_k16", 32'(leds), 32'h001);
         if (i == 24) chk("norm_leds_k24", 32'(leds), 32'h000);
         if (i >= 24 && i < 40) chk("norm_som", 32'({est, som}), 32'({3'd4, 1'b1}));
         if (i == 40) chk("norm_end_est", 32'(est), 32'h0);
      end

      // BCD borrow
      tempo = 12'h100; conf = 1'b1;
      cycle();
      conf = 1'b0;
      for (int i = 1; i <= 16; i++) begin
         cycle();
         if (i == 8)  chk("borrow_099", 32'(leds), 32'h099);
         if (i == 16) chk("borrow_098", 32'(leds), 32'h098);
      end
      cancela = 1'b1; cycle(); cycle();
      cancela = 1'b0;
      chk("borrow_clear", 32'({est, leds}), 32'h0);

      // Rejected starts
      tempo = 12'h0A5; conf = 1'b1; cycle();
      chk("rej_invalid", 32'({est, leds}), 32'h0);
      tempo = 12'h000; cycle();
      chk("rej_zero", 32'({est, leds}), 32'h0);
      tempo = 12'h005; porta = 1'b1; cycle();
      chk("rej_door", 32'({est, leds}), 32'h0);
      idle_inputs(); cycle();

      // Pause at leds=007, pre=5, then resume; potencia=1 modulation on the way
      tempo = 12'h009; potencia = 2'd1; conf = 1'b1;
      cycle();
      conf = 1'b0;
      for (int i = 1; i <= 21; i++) begin
         cycle();
         chk("pot1_aquec", 32'(aquec), 32'((i % 8) < 4));
      end
      porta = 1'b1; cycle();
      chk("pause_est", 32'(est), 32'h3);
      chk("pause_outs", 32'({motor, aquec, luz}), 32'b001);
      chk("pause_leds", 32'(leds), 32'h007);
      porta = 1'b0; cycle();
      conf = 1'b1; cycle();
      conf = 1'b0;
      cycle(); cycle(); cycle();
      chk("resume_leds", 32'(leds), 32'h006);
      cancela = 1'b1; cycle();
      chk("cancel_pause", 32'(est), 32'h3);
      cycle();
      chk("cancel_clear", 32'({est, leds}), 32'h0);
      cancela = 1'b0;

      // potencia=0: heater only in first quarter
      tempo = 12'h002; potencia = 2'd0; conf = 1'b1;
      cycle();
      conf = 1'b0;
      for (int i = 1; i <= 12; i++) begin
         cycle();
         chk("pot0_aquec", 32'(aquec), 32'((i % 8) < 2));
      end
      cancela = 1'b1; cycle(); cycle();
      cancela = 1'b0;

      // Random traffic against the model
      for (int i = 0; i < 1500; i++) begin
         tempo    = {4'd0, 4'($urandom_range(0, 1)), 4'($urandom_range(0, 11))};
         potencia = 2'($urandom);
         conf     = ($urandom_range(0, 3) == 0);
         cancela  = ($urandom_range(0, 40) == 0);
         porta    = ($urandom_range(0, 30) == 0);
         cycle();
      end

      // Asynchronous reset mid-cook
      idle_inputs(); cycle();
      tempo = 12'h005; potencia = 2'd3; conf = 1'b1;
      cycle();
      conf = 1'b0;
      cycle(); cycle();
      chk("pre_rst_motor", 32'(motor), 32'h1);
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      chk("async_rst_outs", 32'({motor, aquec, som, luz}), 32'h0);
      chk("async_rst_regs", 32'({est, leds}), 32'h0);
      rst_n = 1'b1;
      cycle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
